// File: rtl/otter_crypto_pkg.sv
// ---------------------------------------------------------------------------
// otter_crypto_pkg
// Shared types and constants for the ENCRY sequencer in the OTTER core:
//   crypto_state_t   - sequencer FSM states (IDLE, RUN, DONE)
//   CRYPTO_ENC/DEC   - encoding of the CU's cryptoSelOut direction bit
//   OP_ENCRY         - opcode of the custom ENCRY instruction
//   RF_WR_SEL_CRYPTO - register-file write-mux input carrying the result
//   rotl32/rotr32    - 32-bit rotates, amount taken modulo 32
// ---------------------------------------------------------------------------
package otter_crypto_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crypto_state_t;

    localparam logic       CRYPTO_ENC       = 1'b0;
    localparam logic       CRYPTO_DEC       = 1'b1;
    localparam logic [6:0] OP_ENCRY         = 7'b1011011;
    localparam logic [2:0] RF_WR_SEL_CRYPTO = 3'd4;

    // Doubling the word turns a rotate into a plain shift; this also makes an
    // amount of 0 return the input unchanged.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} << amt;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

endpackage

// File: rtl/otter_crypto_keysched.sv
// ---------------------------------------------------------------------------
// otter_crypto_keysched
// Round-key register for the ENCRY sequencer.
//   clk, rst_n - clock, asynchronous active-low reset (key clears to 0)
//   load       - capture key_in as the first round key
//   step       - advance to the next round key (ignored while load is high)
//   dec        - direction: selects initial key on load, rotate sense on step
//   key_in     - raw key operand
//   key_out    - current round key
// Encrypt starts from the raw key and rotates left each round. Decrypt starts
// from the last encrypt key and rotates right, walking the same schedule
// backwards.
// ---------------------------------------------------------------------------
module otter_crypto_keysched
    import otter_crypto_pkg::*;
#(
    parameter int ROUNDS  = 8,
    parameter int KEY_ROT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        dec,
    input  logic [31:0] key_in,
    output logic [31:0] key_out
);

    localparam logic [4:0] STEP_AMT = 5'(KEY_ROT % 32);
    // Total left rotation applied by the time encrypt reaches its last round.
    localparam logic [4:0] LAST_AMT = 5'((KEY_ROT * (ROUNDS - 1)) % 32);

    logic [31:0] key_d;
    logic [31:0] key_q;

    always_comb begin
        key_d = key_q;
        if (load) begin
            key_d = (dec == CRYPTO_DEC) ? rotl32(key_in, LAST_AMT) : key_in;
        end else if (step) begin
            key_d = (dec == CRYPTO_DEC) ? rotr32(key_q, STEP_AMT) : rotl32(key_q, STEP_AMT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign key_out = key_q;

endmodule

// File: rtl/otter_crypto_ctrl.sv
// ---------------------------------------------------------------------------
// otter_crypto_ctrl
// Multi-cycle sequencer for the ENCRY instruction. Captures operand and key on
// CRYPTO_START, drives an external combinational round function for ROUNDS
// cycles, then holds the result for the register file until CRYPTO_ACK.
//   CLK, RST_N     - clock, asynchronous active-low reset
//   CRYPTO_START   - one-cycle issue strobe from the CU
//   CRYPTO_SEL     - 0 encrypt / 1 decrypt, sampled with START
//   CRYPTO_DATA    - operand (rs1), sampled with START
//   CRYPTO_KEY     - key (rs2), sampled with START
//   CRYPTO_ACK     - core has written the result back
//   CRYPTO_STALL   - hold PC and pipeline
//   CRYPTO_VALID   - result valid
//   CRYPTO_RESULT  - result to RF write mux (0 when not valid)
//   RND_DATA/KEY/IDX/DEC - registered inputs of the external round function
//   RND_NEXT       - round function output
// Timing: START in cycle 0, RUN in cycles 1..ROUNDS, VALID from ROUNDS+1.
// ---------------------------------------------------------------------------
module otter_crypto_ctrl
    import otter_crypto_pkg::*;
#(
    parameter int ROUNDS  = 8,
    parameter int IDX_W   = 3,
    parameter int KEY_ROT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CRYPTO_START,
    input  logic             CRYPTO_SEL,
    input  logic [31:0]      CRYPTO_DATA,
    input  logic [31:0]      CRYPTO_KEY,
    input  logic             CRYPTO_ACK,
    output logic             CRYPTO_STALL,
    output logic             CRYPTO_VALID,
    output logic [31:0]      CRYPTO_RESULT,
    output logic [31:0]      RND_DATA,
    output logic [31:0]      RND_KEY,
    output logic [IDX_W-1:0] RND_IDX,
    output logic             RND_DEC,
    input  logic [31:0]      RND_NEXT
);

    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(ROUNDS - 1);

    crypto_state_t    state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             load_go;
    logic             ks_load;
    logic             ks_step;
    logic             ks_dec;
    logic [31:0]      key_cur;

    // A new operation is accepted from IDLE, or from DONE when the core
    // acknowledges the old result in the same cycle (back-to-back ENCRY).
    // START anywhere else is a protocol violation and is dropped.
    assign load_go = CRYPTO_START &
                     ((state_q == IDLE) | ((state_q == DONE) & CRYPTO_ACK));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        ks_load  = 1'b0;
        ks_step  = 1'b0;
        ks_dec   = sel_q;

        if (load_go) begin
            data_d  = CRYPTO_DATA;
            sel_d   = CRYPTO_SEL;
            idx_d   = (CRYPTO_SEL == CRYPTO_DEC) ? LAST_RND : '0;
            cnt_d   = '0;
            ks_load = 1'b1;
            ks_dec  = CRYPTO_SEL;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    data_d  = RND_NEXT;
                    ks_step = 1'b1;
                    idx_d   = (sel_q == CRYPTO_DEC) ? idx_q - 1'b1 : idx_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_RND) begin
                        result_d = RND_NEXT;
                        cnt_d    = '0;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (CRYPTO_ACK) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            data_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
        end
    end

    otter_crypto_keysched #(
        .ROUNDS  (ROUNDS),
        .KEY_ROT (KEY_ROT)
    ) u_keysched (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (ks_load),
        .step    (ks_step),
        .dec     (ks_dec),
        .key_in  (CRYPTO_KEY),
        .key_out (key_cur)
    );

    // Combinational from START/ACK so the issuing instruction is frozen in
    // the same cycle; forced low while reset is asserted.
    assign CRYPTO_STALL  = RST_N & (load_go | (state_q == RUN));
    assign CRYPTO_VALID  = valid_q;
    assign CRYPTO_RESULT = valid_q ? result_q : '0;

    assign RND_DATA = data_q;
    assign RND_KEY  = key_cur;
    assign RND_IDX  = idx_q;
    assign RND_DEC  = sel_q;

endmodule
